// File: rtl/hazard_unit_if.sv
// Decode-stage inputs and pipeline-control outputs exchanged between the datapath and the
// hazard unit.
interface hazard_unit_if;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic       UsesRsD;
    logic       UsesRtD;
    logic [4:0] WriteRegD;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       MdStartD;
    logic       UsesHiLoD;
    logic       PCSrcE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic       MdBusy;

    modport master (
        output RsD, RtD, UsesRsD, UsesRtD, WriteRegD, RegWriteD, MemtoRegD,
               MdStartD, UsesHiLoD, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, MdBusy
    );

    modport slave (
        input  RsD, RtD, UsesRsD, UsesRtD, WriteRegD, RegWriteD, MemtoRegD,
               MdStartD, UsesHiLoD, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, MdBusy
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: tracks E/M/W destination state, selects forwarding paths,
// and raises stalls/flushes for load-use, mul/div HI/LO use and taken branches.
module hazard_unit (
    input  logic          clk,
    input  logic          resetn,
    hazard_unit_if.slave  hz
);

    logic [4:0] r_rs_e;
    logic [4:0] r_rt_e;
    logic [4:0] r_wr_e;
    logic       r_rw_e;
    logic       r_mtr_e;
    logic       r_mds_e;
    logic [4:0] r_wr_m;
    logic       r_rw_m;
    logic [4:0] r_wr_w;
    logic       r_rw_w;
    logic [4:0] r_md_cnt;

    logic       w_lwstall;
    logic       w_mdstall;
    logic       w_stall;
    logic       w_flush_e;
    logic       w_md_busy;

    assign w_md_busy = (r_md_cnt != 5'd0);

    always_comb begin
        w_lwstall = 1'b0;
        w_mdstall = 1'b0;
        w_stall   = 1'b0;
        w_flush_e = 1'b0;
        if (r_mtr_e && r_rw_e && (r_wr_e != 5'd0)) begin
            w_lwstall = (hz.UsesRsD && (hz.RsD == r_wr_e)) ||
                        (hz.UsesRtD && (hz.RtD == r_wr_e));
        end
        w_mdstall = hz.UsesHiLoD && (w_md_busy || r_mds_e);
        // A taken branch makes the Decode instruction wrong-path, so it overrides any stall.
        w_stall   = (w_lwstall || w_mdstall) && !hz.PCSrcE;
        w_flush_e = w_stall || hz.PCSrcE;
    end

    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (r_rw_m && (r_wr_m != 5'd0) && (r_wr_m == r_rs_e)) begin
            hz.ForwardAE = 2'b10;
        end else if (r_rw_w && (r_wr_w != 5'd0) && (r_wr_w == r_rs_e)) begin
            hz.ForwardAE = 2'b01;
        end
        if (r_rw_m && (r_wr_m != 5'd0) && (r_wr_m == r_rt_e)) begin
            hz.ForwardBE = 2'b10;
        end else if (r_rw_w && (r_wr_w != 5'd0) && (r_wr_w == r_rt_e)) begin
            hz.ForwardBE = 2'b01;
        end
    end

    assign hz.StallF = w_stall;
    assign hz.StallD = w_stall;
    assign hz.FlushD = hz.PCSrcE;
    assign hz.FlushE = w_flush_e;
    assign hz.MdBusy = w_md_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rs_e  <= 5'd0;
            r_rt_e  <= 5'd0;
            r_wr_e  <= 5'd0;
            r_rw_e  <= 1'b0;
            r_mtr_e <= 1'b0;
            r_mds_e <= 1'b0;
        end else if (w_flush_e) begin
            r_rs_e  <= 5'd0;
            r_rt_e  <= 5'd0;
            r_wr_e  <= 5'd0;
            r_rw_e  <= 1'b0;
            r_mtr_e <= 1'b0;
            r_mds_e <= 1'b0;
        end else begin
            r_rs_e  <= hz.RsD;
            r_rt_e  <= hz.RtD;
            r_wr_e  <= hz.WriteRegD;
            r_rw_e  <= hz.RegWriteD;
            r_mtr_e <= hz.MemtoRegD;
            r_mds_e <= hz.MdStartD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_m <= 5'd0;
            r_rw_m <= 1'b0;
            r_wr_w <= 5'd0;
            r_rw_w <= 1'b0;
        end else begin
            r_wr_m <= r_wr_e;
            r_rw_m <= r_rw_e;
            r_wr_w <= r_wr_m;
            r_rw_w <= r_rw_m;
        end
    end

    // Restart semantics: a new start while busy reloads the full latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_md_cnt <= 5'd0;
        end else if (r_mds_e) begin
            r_md_cnt <= 5'd31;
        end else if (r_md_cnt != 5'd0) begin
            r_md_cnt <= r_md_cnt - 5'd1;
        end
    end

endmodule
